// File: rtl/zmod_pkg.sv
// Shared types and helpers for the zmod receive framing aligner.
// The one-hot decoder works on a word zero-extended to MAX_W bits.
package zmod_pkg;

  localparam int unsigned MAX_W = 16;
  localparam int unsigned POS_W = 4;

  typedef enum logic [1:0] {
    SEARCH,
    CONFIRM,
    LOCKED
  } zmod_align_state_t;

  typedef struct packed {
    logic             valid;
    logic [POS_W-1:0] pos;
  } onehot_t;

  // valid only when exactly one bit is set; pos is that bit's index
  function automatic onehot_t onehot_pos(input logic [MAX_W-1:0] word);
    onehot_t     res;
    int unsigned ones;
    res  = '0;
    ones = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (word[i]) begin
        ones++;
        res.pos = POS_W'(i);
      end
    end
    res.valid = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/zmod_lane_checker.sv
// Per-lane incrementing-counter checker with a saturating mismatch count.
// The first active cycle seeds the reference; any inactive cycle re-arms the seed.
module zmod_lane_checker #(
  parameter int unsigned W     = 8,
  parameter int unsigned ERR_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             active,
  input  logic             err_clear,
  input  logic [W-1:0]     din,
  output logic             lane_err,
  output logic [ERR_W-1:0] err_count
);

  logic             seeded_q;
  logic [W-1:0]     prev_q;
  logic             lane_err_q;
  logic [ERR_W-1:0] count_q;
  logic [W-1:0]     prev_inc;
  logic             mismatch;

  always_comb begin
    prev_inc = prev_q + W'(1);
    mismatch = active && seeded_q && (din != prev_inc);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seeded_q   <= 1'b0;
      prev_q     <= '0;
      lane_err_q <= 1'b0;
      count_q    <= '0;
    end else begin
      seeded_q   <= active;
      lane_err_q <= mismatch;
      if (active) begin
        prev_q <= din;
      end
      // clear wins over a same-cycle increment
      if (err_clear) begin
        count_q <= '0;
      end else if (mismatch && (count_q != '1)) begin
        count_q <= count_q + ERR_W'(1);
      end
    end
  end

  assign lane_err  = lane_err_q;
  assign err_count = count_q;

endmodule

// File: rtl/zmod_rx_aligner.sv
// zmod LVDS receive framing aligner: sync-lane lock FSM with hysteresis, per-lane
// barrel alignment of the data lanes and per-lane test-counter checking.
module zmod_rx_aligner
  import zmod_pkg::*;
#(
  parameter int unsigned N_LANES    = 3,
  parameter int unsigned W          = 8,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned ERR_W      = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [W-1:0]             sync_in,
  input  logic [N_LANES*W-1:0]     data_in,
  input  logic                     check_en,
  input  logic                     err_clear,
  output logic [N_LANES*W-1:0]     dout,
  output logic                     dout_valid,
  output logic [$clog2(W)-1:0]     shift,
  output logic                     locked,
  output logic [N_LANES-1:0]       lane_err,
  output logic [N_LANES*ERR_W-1:0] err_count
);

  localparam int unsigned SW = $clog2(W);
  localparam int unsigned CW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW = $clog2(UNLOCK_CNT + 1);

  zmod_align_state_t state_q, state_d;
  logic [SW-1:0]     cand_q, cand_d;
  logic [SW-1:0]     shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MW-1:0]     miss_q, miss_d;

  onehot_t           dec;
  logic              sync_valid;
  logic [SW-1:0]     sync_pos;

  always_comb begin
    dec        = onehot_pos(MAX_W'(sync_in));
    sync_valid = dec.valid;
    sync_pos   = SW'(dec.pos);
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    unique case (state_q)
      SEARCH: begin
        if (sync_valid) begin
          cand_d  = sync_pos;
          cnt_d   = CW'(1);
          state_d = CONFIRM;
        end
      end
      CONFIRM: begin
        if (sync_valid && (sync_pos == cand_q)) begin
          if (cnt_q == CW'(LOCK_CNT - 1)) begin
            shift_d = cand_q;
            cnt_d   = '0;
            miss_d  = '0;
            state_d = LOCKED;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          // the offending word is discarded, not taken as a new candidate
          cnt_d   = '0;
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (sync_valid && (sync_pos == shift_q)) begin
          miss_d = '0;
        end else if (miss_q == MW'(UNLOCK_CNT - 1)) begin
          miss_d  = '0;
          state_d = SEARCH;
        end else begin
          miss_d = miss_q + MW'(1);
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SEARCH;
      cand_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
    end
  end

  // Datapath: newest word in the upper half of a two-word window per lane
  logic [N_LANES-1:0][2*W-1:0] win_q;
  logic [N_LANES*W-1:0]        dout_d, dout_q;
  logic                        locked_dly_q, dout_valid_q;

  always_comb begin
    dout_d = '0;
    for (int l = 0; l < N_LANES; l++) begin
      dout_d[l*W +: W] = W'(win_q[l] >> shift_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_q        <= '0;
      dout_q       <= '0;
      locked_dly_q <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      for (int l = 0; l < N_LANES; l++) begin
        win_q[l] <= {data_in[l*W +: W], win_q[l][2*W-1:W]};
      end
      dout_q       <= dout_d;
      locked_dly_q <= (state_q == LOCKED);
      dout_valid_q <= locked_dly_q;
    end
  end

  logic check_active;
  assign check_active = dout_valid_q && check_en;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    zmod_lane_checker #(
      .W     (W),
      .ERR_W (ERR_W)
    ) u_checker (
      .clk       (clk),
      .resetn    (resetn),
      .active    (check_active),
      .err_clear (err_clear),
      .din       (dout_q[g*W +: W]),
      .lane_err  (lane_err[g]),
      .err_count (err_count[g*ERR_W +: ERR_W])
    );
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign shift      = shift_q;
  assign locked     = (state_q == LOCKED);

endmodule
